// File: rtl/sd_wrrmux_pkg.sv
// Shared constants for the weighted round-robin srdy/drdy multiplexer.
// Defaults match the library's common four-channel byte-wide configuration.
package sd_wrrmux_pkg;
    localparam int SD_DEF_WIDTH  = 8;
    localparam int SD_DEF_INPUTS = 4;
    localparam int SD_DEF_WBITS  = 4;
endpackage

// File: rtl/sd_wrrmux_if.sv
// Producer-side and consumer-side handshake bundle for sd_wrrmux.
// The slave modport is the mux's own view; master is the environment's view.
interface sd_wrrmux_if #(
    parameter int width  = 8,
    parameter int inputs = 4,
    parameter int wbits  = 4
);
    logic [width*inputs-1:0] c_data;
    logic [inputs-1:0]       c_srdy;
    logic [inputs-1:0]       c_eop;
    logic [inputs-1:0]       c_drdy;
    logic [wbits*inputs-1:0] cfg_weight;
    logic [width-1:0]        p_data;
    logic                    p_eop;
    logic                    p_srdy;
    logic                    p_drdy;
    logic [inputs-1:0]       p_grant;

    modport slave (
        input  c_data, c_srdy, c_eop, cfg_weight, p_drdy,
        output c_drdy, p_data, p_eop, p_srdy, p_grant
    );

    modport master (
        output c_data, c_srdy, c_eop, cfg_weight, p_drdy,
        input  c_drdy, p_data, p_eop, p_srdy, p_grant
    );
endinterface

// File: rtl/sd_wrrmux_rr_pick.sv
// Rotating priority picker: returns the first requester strictly after the
// one-hot 'last', with 'last' itself considered only after all others.
module sd_rr_pick #(
    parameter int inputs = 4
) (
    input  logic [inputs-1:0] req,
    input  logic [inputs-1:0] last,
    output logic [inputs-1:0] next
);
    always_comb begin
        int   base;
        int   idx;
        logic found;
        base  = inputs - 1;
        idx   = 0;
        found = 1'b0;
        next  = '0;
        for (int i = 0; i < inputs; i++) begin
            if (last[i]) base = i;
        end
        for (int k = 1; k <= inputs; k++) begin
            idx = (base + k) % inputs;
            if (!found && req[idx]) begin
                next[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sd_wrrmux.sv
// Weighted round-robin srdy/drdy mux with packet locking and zero-cycle
// arbitration; grant state is registered so presented data holds under stall.
module sd_wrrmux
    import sd_wrrmux_pkg::*;
#(
    parameter int width    = SD_DEF_WIDTH,
    parameter int inputs   = SD_DEF_INPUTS,
    parameter int wbits    = SD_DEF_WBITS,
    parameter bit pkt_mode = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    sd_wrrmux_if.slave  bus
);
    logic [inputs-1:0] req;
    logic [inputs-1:0] pick;
    logic [inputs-1:0] eff;
    logic [inputs-1:0] gnt_reg;
    logic [wbits-1:0]  credit_reg;
    logic              locked_reg;
    logic [width-1:0]  data_sel;
    logic              eop_sel;
    logic [wbits-1:0]  w_eff;
    logic              p_srdy;
    logic              p_eop;
    logic              xfer;
    logic              xfer_eop;

    // A zero weight removes the channel from arbitration entirely.
    for (genvar gi = 0; gi < inputs; gi++) begin : g_req
        assign req[gi] = bus.c_srdy[gi] & (bus.cfg_weight[gi*wbits +: wbits] != '0);
    end

    sd_rr_pick #(.inputs(inputs)) u_pick (
        .req  (req),
        .last (gnt_reg),
        .next (pick)
    );

    always_comb begin
        eff = '0;
        if (!reset_n)
            eff = '0;
        else if (locked_reg)
            eff = gnt_reg;
        else if ((|(req & gnt_reg)) && (credit_reg != '0))
            eff = gnt_reg;
        else
            eff = pick;
    end

    always_comb begin
        data_sel = '0;
        eop_sel  = 1'b0;
        w_eff    = '0;
        for (int i = 0; i < inputs; i++) begin
            data_sel = data_sel | ({width{eff[i]}} & bus.c_data[i*width +: width]);
            eop_sel  = eop_sel  | (eff[i] & bus.c_eop[i]);
            w_eff    = w_eff    | ({wbits{eff[i]}} & bus.cfg_weight[i*wbits +: wbits]);
        end
    end

    assign p_srdy      = |(eff & bus.c_srdy);
    assign p_eop       = pkt_mode ? eop_sel : (|eff);
    assign bus.p_srdy  = p_srdy;
    assign bus.p_eop   = p_eop;
    assign bus.p_data  = data_sel;
    assign bus.p_grant = eff;
    assign bus.c_drdy  = eff & {inputs{bus.p_drdy}};

    assign xfer     = p_srdy & bus.p_drdy;
    assign xfer_eop = xfer & p_eop;

    // The reload/switch path commits even without a transfer, pinning the
    // presented channel while downstream back-pressures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_reg    <= {1'b1, {(inputs-1){1'b0}}};
            credit_reg <= '0;
            locked_reg <= 1'b0;
        end else if (eff != '0) begin
            if ((eff == gnt_reg) && (credit_reg != '0)) begin
                if (xfer_eop)
                    credit_reg <= credit_reg - wbits'(1);
            end else begin
                gnt_reg    <= eff;
                credit_reg <= (xfer_eop && (w_eff != '0)) ? w_eff - wbits'(1) : w_eff;
            end
            if (pkt_mode && xfer)
                locked_reg <= ~p_eop;
        end
    end
endmodule

// File: tb/tb_sd_wrrmux.sv
// Directed and randomized scoreboard bench for sd_wrrmux (one instance per
// packet mode, both fed from the same stimulus).
module tb_sd_wrrmux;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int WB = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [W*N-1:0]  c_data = '0;
    logic [N-1:0]    c_srdy = '0;
    logic [N-1:0]    c_eop = '0;
    logic [WB*N-1:0] cfg_weight = 16'h1111;
    logic            p_drdy = 1'b1;

    always #5 clk = ~clk;

    sd_wrrmux_if #(.width(W), .inputs(N), .wbits(WB)) bus0 ();
    sd_wrrmux_if #(.width(W), .inputs(N), .wbits(WB)) bus1 ();

    assign bus0.c_data = c_data;  assign bus1.c_data = c_data;
    assign bus0.c_srdy = c_srdy;  assign bus1.c_srdy = c_srdy;
    assign bus0.c_eop  = c_eop;   assign bus1.c_eop  = c_eop;
    assign bus0.cfg_weight = cfg_weight; assign bus1.cfg_weight = cfg_weight;
    assign bus0.p_drdy = p_drdy;  assign bus1.p_drdy = p_drdy;

    sd_wrrmux #(.width(W), .inputs(N), .wbits(WB), .pkt_mode(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    sd_wrrmux #(.width(W), .inputs(N), .wbits(WB), .pkt_mode(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    int mon = 0;
    logic          o_srdy, o_eop;
    logic [N-1:0]  o_grant, o_drdy;
    logic [W-1:0]  o_data;

    always_comb begin
        if (mon == 0) begin
            o_srdy = bus0.p_srdy; o_eop = bus0.p_eop; o_grant = bus0.p_grant;
            o_drdy = bus0.c_drdy; o_data = bus0.p_data;
        end else begin
            o_srdy = bus1.p_srdy; o_eop = bus1.p_eop; o_grant = bus1.p_grant;
            o_drdy = bus1.c_drdy; o_data = bus1.p_data;
        end
    end

    typedef struct packed {
        logic [N-1:0] g;
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] chq[N][$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ch(input int i, input logic [W-1:0] d, input logic e);
        c_data[i*W +: W] = d;
        c_eop[i] = e;
    endtask

    task automatic push(input logic [N-1:0] g, input logic [W-1:0] d, input logic e);
        exp_t x;
        x.g = g; x.d = d; x.e = e;
        exp_q.push_back(x);
    endtask

    // Sample settled outputs, retire one scoreboard entry per transfer, then
    // advance to the next negedge where stimulus changes.
    task automatic cycle();
        exp_t x;
        #2;
        if (o_srdy && p_drdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 1);
            end else begin
                x = exp_q.pop_front();
                chk("sb_grant", 32'(o_grant), 32'(x.g));
                chk("sb_data",  32'(o_data),  32'(x.d));
                chk("sb_eop",   32'(o_eop),   32'(x.e));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        c_srdy  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_data_base(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) drive_ch(i, base + W'(i), 1'b0);
    endtask

    logic [N-1:0]  acc;
    logic [5:0]    seq[N];
    logic [8:0]    x9;
    logic [W-1:0]  rd;
    logic          re;
    logic          own_v, prev_stall;
    logic [N-1:0]  own_g;
    logic [12:0]   prev_val;
    int            gidx;

    initial begin
        // Reset with every channel requesting: nothing may leak out.
        mon = 0;
        c_srdy = 4'hF; cfg_weight = 16'h1111; p_drdy = 1'b1;
        set_data_base(8'hA0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_srdy",  32'(bus0.p_srdy), 0);
        chk("rst_drdy",  32'(bus0.c_drdy), 0);
        chk("rst_grant", 32'(bus1.p_grant), 0);
        chk("rst_data",  32'(bus1.p_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(4'b0001, 8'hA0, 1'b1); push(4'b0010, 8'hA1, 1'b1);
        push(4'b0100, 8'hA2, 1'b1); push(4'b1000, 8'hA3, 1'b1);
        push(4'b0001, 8'hA0, 1'b1);
        repeat (5) cycle();
        c_srdy = '0;
        cycle();
        chk("s1_drain", 32'(exp_q.size()), 0);

        // Weights 3,1,1,1 with continuous single-beat traffic.
        do_reset();
        cfg_weight = 16'h1113; c_srdy = 4'hF;
        set_data_base(8'hB0);
        repeat (2) begin
            for (int k = 0; k < 3; k++) push(4'b0001, 8'hB0, 1'b1);
            push(4'b0010, 8'hB1, 1'b1); push(4'b0100, 8'hB2, 1'b1); push(4'b1000, 8'hB3, 1'b1);
        end
        repeat (12) cycle();
        c_srdy = '0;
        cycle();
        chk("s2_drain", 32'(exp_q.size()), 0);

        // Packet lock: channel 1 sends 4 beats with a 2-cycle gap, channel 2 waits.
        mon = 1;
        do_reset();
        cfg_weight = 16'h1111; p_drdy = 1'b1;
        c_srdy = 4'b0110;
        drive_ch(1, 8'h11, 1'b0); drive_ch(2, 8'h21, 1'b1);
        push(4'b0010, 8'h11, 1'b0); cycle();
        drive_ch(1, 8'h12, 1'b0);
        push(4'b0010, 8'h12, 1'b0); cycle();
        c_srdy = 4'b0100;
        repeat (2) begin
            #2;
            chk("gap_srdy",  32'(o_srdy), 0);
            chk("gap_grant", 32'(o_grant), 32'(4'b0010));
            chk("gap_drdy2", 32'(o_drdy[2]), 0);
            @(negedge clk);
        end
        c_srdy = 4'b0110;
        drive_ch(1, 8'h13, 1'b0);
        push(4'b0010, 8'h13, 1'b0); cycle();
        drive_ch(1, 8'h14, 1'b1);
        push(4'b0010, 8'h14, 1'b1); cycle();
        c_srdy = 4'b0100;
        push(4'b0100, 8'h21, 1'b1); cycle();
        c_srdy = '0;
        cycle();
        chk("s3_drain", 32'(exp_q.size()), 0);

        // Back-pressure: channel 3 presented, channel 0 arrives during stall.
        do_reset();
        p_drdy = 1'b0; c_srdy = 4'b1000;
        drive_ch(3, 8'h33, 1'b1); drive_ch(0, 8'h03, 1'b1);
        cycle();
        c_srdy = 4'b1001;
        repeat (5) begin
            #2;
            chk("bp_grant", 32'(o_grant), 32'(4'b1000));
            chk("bp_data",  32'(o_data), 32'h33);
            chk("bp_srdy",  32'(o_srdy), 1);
            @(negedge clk);
        end
        p_drdy = 1'b1;
        push(4'b1000, 8'h33, 1'b1); cycle();
        c_srdy = 4'b0001;
        push(4'b0001, 8'h03, 1'b1); cycle();
        c_srdy = '0;
        cycle();
        chk("s4_drain", 32'(exp_q.size()), 0);

        // Zero weight on channel 2 excludes it from rotation.
        mon = 0;
        do_reset();
        cfg_weight = 16'h1011; c_srdy = 4'hF; p_drdy = 1'b1;
        set_data_base(8'hC0);
        repeat (2) begin
            push(4'b0001, 8'hC0, 1'b1); push(4'b0010, 8'hC1, 1'b1); push(4'b1000, 8'hC3, 1'b1);
        end
        repeat (6) begin
            #1;
            chk("w0_drdy2", 32'(o_drdy[2]), 0);
            cycle();
        end
        c_srdy = '0;
        cycle();
        chk("s5_drain", 32'(exp_q.size()), 0);

        // Random traffic on the packet-mode instance with per-channel queues.
        mon = 1;
        do_reset();
        cfg_weight = 16'h1312; c_eop = '0;
        acc = '0; own_v = 1'b0; own_g = '0; prev_stall = 1'b0; prev_val = '0;
        for (int i = 0; i < N; i++) seq[i] = '0;
        for (int t = 0; t < 10000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) c_srdy[i] = 1'b0;
                if (!c_srdy[i] && ($urandom_range(1, 0) == 1)) begin
                    seq[i] = seq[i] + 6'd1;
                    rd = {2'(i), seq[i]};
                    re = ($urandom_range(2, 0) == 0);
                    drive_ch(i, rd, re);
                    c_srdy[i] = 1'b1;
                    chq[i].push_back({re, rd});
                end
            end
            p_drdy = ($urandom_range(3, 0) != 0);
            #2;
            acc = c_srdy & o_drdy;
            if (prev_stall)
                chk("rnd_stable", 32'({o_srdy, o_grant, o_data}), 32'(prev_val));
            if (o_srdy && p_drdy) begin
                chk("rnd_onehot", 32'($countones(o_grant)), 1);
                gidx = 0;
                for (int i = 0; i < N; i++) if (o_grant[i]) gidx = i;
                if (own_v)
                    chk("rnd_interleave", 32'(o_grant), 32'(own_g));
                if (chq[gidx].size() == 0) begin
                    chk("rnd_underflow", 32'(chq[gidx].size()), 1);
                end else begin
                    x9 = chq[gidx].pop_front();
                    chk("rnd_data", 32'(o_data), 32'(x9[7:0]));
                    chk("rnd_eop",  32'(o_eop),  32'(x9[8]));
                end
                own_v = ~o_eop;
                own_g = o_grant;
            end
            prev_stall = o_srdy & ~p_drdy;
            prev_val   = {o_srdy, o_grant, o_data};
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
